// File: rtl/pcecd_scsi_target.sv
// PC Engine CD SCSI target: bus phase sequencer for COMMAND, DATA IN, STATUS and
// MESSAGE IN with a REQ/ACK handshake toward the initiator.
// Optional REQ watchdog enabled by defining PCECD_TARGET_TIMEOUT_EN.
module pcecd_scsi_target #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_i,
    input  logic        ack_i,
    input  logic        rst_i,
    input  logic [7:0]  db_i,
    output logic [7:0]  db_o,
    output logic        bsy_o,
    output logic        req_o,
    output logic        msg_o,
    output logic        cd_o,
    output logic        io_o,
    output logic [79:0] cmd_o,
    output logic [3:0]  cmd_len_o,
    output logic        cmd_valid_o,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    input  logic        status_valid_i,
    input  logic [7:0]  status_i
);

    typedef enum logic [2:0] {
        BUS_FREE, COMMAND, EXEC, DATA_IN, STATUS, MSG_IN
    } state_t;

    state_t     state, state_nx;
    logic       got;          // ACK seen for current byte, waiting for ACK release
    logic       have;         // a byte is parked on db_o awaiting its REQ
    logic       status_pend;
    logic [7:0] status_lat;
    logic [3:0] idx;
    logic       to_hit, abort, hs_done, hs_clear, req_raise, data_load, cmd_last, status_go;

`ifdef PCECD_TARGET_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Watchdog counts cycles with REQ high and ACK low; restarts whenever either breaks.
    always_ff @(posedge clk) begin
        if (reset || !req_o || ack_i)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end

    assign to_hit = req_o & ~ack_i & (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the limit parameter is inert.
    assign to_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    assign abort     = rst_i | to_hit;
    assign hs_done   = req_o & ack_i;
    assign hs_clear  = got & ~ack_i;
    assign req_raise = ~req_o & ~ack_i & ~got & ((state == COMMAND) | have);
    assign cmd_last  = (idx == cmd_len_o - 4'd1);
    assign status_go = status_pend | status_valid_i;
    assign data_load = ~reset & ~abort & (state == DATA_IN) & ~have & ~got
                       & ~req_o & ~ack_i & data_valid_i;
    assign data_ready_o = data_load;
    assign bsy_o        = (state != BUS_FREE);

    // Phase lines decoded from the current state.
    always_comb begin
        {msg_o, cd_o, io_o} = 3'b000;
        case (state)
            COMMAND: {msg_o, cd_o, io_o} = 3'b010;
            DATA_IN: {msg_o, cd_o, io_o} = 3'b001;
            STATUS:  {msg_o, cd_o, io_o} = 3'b011;
            MSG_IN:  {msg_o, cd_o, io_o} = 3'b111;
            default: {msg_o, cd_o, io_o} = 3'b000;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= BUS_FREE;
        else
            state <= state_nx;
    end

    // Next-state selection; bus reset or watchdog always returns to BUS_FREE.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = BUS_FREE;
        end else begin
            case (state)
                BUS_FREE: if (sel_i) state_nx = COMMAND;
                COMMAND:  if (hs_clear && cmd_last) state_nx = EXEC;
                EXEC: begin
                    if (data_valid_i)        state_nx = DATA_IN;
                    else if (status_valid_i) state_nx = STATUS;
                end
                DATA_IN:  if (!have && !got && !req_o && !data_valid_i && status_go)
                              state_nx = STATUS;
                STATUS:   if (hs_clear) state_nx = MSG_IN;
                MSG_IN:   if (hs_clear) state_nx = BUS_FREE;
                default:  state_nx = BUS_FREE;
            endcase
        end
    end

    // Handshake, command capture and byte staging on db_o.
    always_ff @(posedge clk) begin
        cmd_valid_o <= 1'b0;
        if (reset || abort) begin
            req_o       <= 1'b0;
            got         <= 1'b0;
            have        <= 1'b0;
            idx         <= '0;
            db_o        <= 8'h00;
            cmd_o       <= '0;
            cmd_len_o   <= '0;
            status_lat  <= 8'h00;
            status_pend <= 1'b0;
        end else begin
            if (state == BUS_FREE && sel_i) begin
                idx         <= '0;
                cmd_o       <= '0;
                cmd_len_o   <= '0;
                got         <= 1'b0;
                have        <= 1'b0;
                status_pend <= 1'b0;
                db_o        <= 8'h00;
            end
            if (req_raise)
                req_o <= 1'b1;
            if (hs_done) begin
                req_o <= 1'b0;
                got   <= 1'b1;
                have  <= 1'b0;
                if (state == COMMAND) begin
                    cmd_o[8*idx +: 8] <= db_i;
                    if (idx == 4'd0)
                        cmd_len_o <= (db_i[7:5] == 3'd0) ? 4'd6 : 4'd10;
                end
            end
            if (hs_clear) begin
                got <= 1'b0;
                case (state)
                    COMMAND: begin
                        if (cmd_last) cmd_valid_o <= 1'b1;
                        else          idx <= idx + 4'd1;
                    end
                    STATUS: begin
                        db_o <= 8'h00;
                        have <= 1'b1;
                    end
                    MSG_IN:  db_o <= 8'h00;
                    default: ;
                endcase
            end
            if ((state == EXEC || state == DATA_IN) && status_valid_i) begin
                status_lat  <= status_i;
                status_pend <= 1'b1;
            end
            if (data_load) begin
                db_o <= data_i;
                have <= 1'b1;
            end
            if (state_nx == STATUS && state != STATUS) begin
                db_o        <= status_valid_i ? status_i : status_lat;
                have        <= 1'b1;
                status_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcecd_scsi_target.sv
// Directed testbench for pcecd_scsi_target.
module tb_pcecd_scsi_target;

    logic        clk = 1'b0;
    logic        reset, sel_i, ack_i, rst_i;
    logic [7:0]  db_i, db_o, data_i, status_i;
    logic        bsy_o, req_o, msg_o, cd_o, io_o;
    logic [79:0] cmd_o;
    logic [3:0]  cmd_len_o;
    logic        cmd_valid_o, data_valid_i, data_ready_o, status_valid_i;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int dr_cnt = 0;

    pcecd_scsi_target #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .sel_i(sel_i), .ack_i(ack_i), .rst_i(rst_i),
        .db_i(db_i), .db_o(db_o), .bsy_o(bsy_o), .req_o(req_o), .msg_o(msg_o),
        .cd_o(cd_o), .io_o(io_o), .cmd_o(cmd_o), .cmd_len_o(cmd_len_o),
        .cmd_valid_o(cmd_valid_o), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .status_valid_i(status_valid_i), .status_i(status_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid_o)  cv_cnt++;
        if (data_ready_o) dr_cnt++;
    end

    task automatic wait_req(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_o === lvl) ok = 1'b1;
        end
    endtask

    // Select the target and hand over n command bytes.
    task automatic send_cmd(input logic [79:0] cmd, input int n);
        bit ok;
        sel_i = 1'b1;
        @(negedge clk);
        sel_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            wait_req(1'b1, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL cmd_req byte %0d: req_o stayed 0, want 1", k); end
            checks++;
            if ({msg_o, cd_o, io_o} !== 3'b010) begin
                errors++; $display("FAIL cmd_phase byte %0d: got %b want 010", k, {msg_o, cd_o, io_o});
            end
            db_i  = cmd[8*k +: 8];
            ack_i = 1'b1;
            wait_req(1'b0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL cmd_req_drop byte %0d: req_o stayed 1", k); end
            ack_i = 1'b0;
        end
        db_i = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    // Offer one DATA IN byte from the backend and take it as initiator.
    task automatic xfer_data(input logic [7:0] b);
        bit ok;
        bit seen;
        data_i       = b;
        data_valid_i = 1'b1;
        seen         = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            if (data_ready_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL data_ready %h: data_ready_o never 1", b); end
        @(negedge clk);
        data_valid_i = 1'b0;
        wait_req(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL data_req %h: req_o stayed 0", b); end
        checks++;
        if ({msg_o, cd_o, io_o} !== 3'b001 || db_o !== b) begin
            errors++; $display("FAIL data_byte: phase %b db %h, want 001 %h", {msg_o, cd_o, io_o}, db_o, b);
        end
        ack_i = 1'b1;
        wait_req(1'b0, ok);
        ack_i = 1'b0;
    endtask

    // One target-to-initiator handshake in STATUS or MSG_IN.
    task automatic xfer_in(input logic [2:0] ph, input logic [7:0] b);
        bit ok;
        wait_req(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL in_req phase %b: req_o stayed 0", ph); end
        checks++;
        if ({msg_o, cd_o, io_o} !== ph || db_o !== b) begin
            errors++; $display("FAIL in_byte: phase %b db %h, want %b %h", {msg_o, cd_o, io_o}, db_o, ph, b);
        end
        ack_i = 1'b1;
        wait_req(1'b0, ok);
        ack_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sel_i = 1'b0; ack_i = 1'b0; rst_i = 1'b0; db_i = 8'h00;
        data_i = 8'h00; data_valid_i = 1'b0; status_valid_i = 1'b0; status_i = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({bsy_o, req_o, msg_o, cd_o, io_o, cmd_valid_o, data_ready_o} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0",
                {bsy_o, req_o, msg_o, cd_o, io_o, cmd_valid_o, data_ready_o});
        end
        checks++;
        if (db_o !== 8'h00) begin errors++; $display("FAIL reset_db: got %h want 00", db_o); end
        checks++;
        if (cmd_o !== 80'h0 || cmd_len_o !== 4'd0) begin
            errors++; $display("FAIL reset_cmd: cmd %h len %0d want 0 0", cmd_o, cmd_len_o);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd6();
        int c0;
        c0 = cv_cnt;
        send_cmd(80'h0, 6);
        checks++;
        if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL cmd6_valid: pulses %0d want 1", cv_cnt - c0); end
        checks++;
        if (cmd_len_o !== 4'd6 || cmd_o !== 80'h0) begin
            errors++; $display("FAIL cmd6_data: len %0d cmd %h want 6 0", cmd_len_o, cmd_o);
        end
        checks++;
        if (bsy_o !== 1'b1 || req_o !== 1'b0 || {msg_o, cd_o, io_o} !== 3'b000) begin
            errors++; $display("FAIL cmd6_exec: bsy %b req %b phase %b want 1 0 000",
                bsy_o, req_o, {msg_o, cd_o, io_o});
        end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++;
        if (bsy_o !== 1'b0 || cmd_len_o !== 4'd0) begin
            errors++; $display("FAIL exec_rst: bsy %b len %0d want 0 0", bsy_o, cmd_len_o);
        end
    endtask

    task automatic test_cmd10();
        int c0;
        c0 = cv_cnt;
        send_cmd(80'h0908_0706_0504_0302_01D8, 10);
        checks++;
        if (cv_cnt - c0 !== 1) begin errors++; $display("FAIL cmd10_valid: pulses %0d want 1", cv_cnt - c0); end
        checks++;
        if (cmd_len_o !== 4'd10) begin errors++; $display("FAIL cmd10_len: got %0d want 10", cmd_len_o); end
        checks++;
        if (cmd_o[7:0] !== 8'hD8 || cmd_o[79:72] !== 8'h09) begin
            errors++; $display("FAIL cmd10_ends: b0 %h b9 %h want d8 09", cmd_o[7:0], cmd_o[79:72]);
        end
        checks++;
        if (cmd_o !== 80'h0908_0706_0504_0302_01D8) begin
            errors++; $display("FAIL cmd10_all: got %h want 0908070605040302 01d8", cmd_o);
        end
    endtask

    task automatic test_data_in();
        int d0;
        d0 = dr_cnt;
        xfer_data(8'hAA);
        xfer_data(8'hBB);
        xfer_data(8'hCC);
        status_i = 8'h02; status_valid_i = 1'b1;
        @(negedge clk);
        status_valid_i = 1'b0; status_i = 8'h00;
        xfer_in(3'b011, 8'h02);
        xfer_in(3'b111, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (bsy_o !== 1'b0 || {msg_o, cd_o, io_o} !== 3'b000 || db_o !== 8'h00) begin
            errors++; $display("FAIL data_end: bsy %b phase %b db %h want 0 000 00",
                bsy_o, {msg_o, cd_o, io_o}, db_o);
        end
        checks++;
        if (dr_cnt - d0 !== 3) begin errors++; $display("FAIL data_ready_cnt: got %0d want 3", dr_cnt - d0); end
    endtask

    task automatic test_exec_both();
        send_cmd(80'h0, 6);
        sel_i = 1'b1;
        repeat (2) @(negedge clk);
        sel_i = 1'b0;
        checks++;
        if (bsy_o !== 1'b1 || req_o !== 1'b0 || {msg_o, cd_o, io_o} !== 3'b000 || cmd_len_o !== 4'd6) begin
            errors++; $display("FAIL sel_ignored: bsy %b req %b phase %b len %0d want 1 0 000 6",
                bsy_o, req_o, {msg_o, cd_o, io_o}, cmd_len_o);
        end
        data_i = 8'h55; data_valid_i = 1'b1; status_i = 8'h04; status_valid_i = 1'b1;
        @(negedge clk);
        status_valid_i = 1'b0; status_i = 8'h00;
        xfer_data(8'h55);
        xfer_in(3'b011, 8'h04);
        xfer_in(3'b111, 8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (bsy_o !== 1'b0) begin errors++; $display("FAIL both_end: bsy %b want 0", bsy_o); end
    endtask

    task automatic test_rst_mid_cmd();
        int c0;
        bit ok;
        c0 = cv_cnt;
        send_cmd(80'h0, 3);
        wait_req(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_req4: req_o stayed 0"); end
        db_i = 8'h44; ack_i = 1'b1; rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bsy_o, req_o, msg_o, cd_o, io_o} !== 5'b0 || db_o !== 8'h00) begin
            errors++; $display("FAIL rst_bus: ctl %b db %h want 00000 00", {bsy_o, req_o, msg_o, cd_o, io_o}, db_o);
        end
        checks++;
        if (cmd_o !== 80'h0 || cmd_len_o !== 4'd0) begin
            errors++; $display("FAIL rst_cmd: cmd %h len %0d want 0 0", cmd_o, cmd_len_o);
        end
        rst_i = 1'b0; ack_i = 1'b0; db_i = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (cv_cnt !== c0 || bsy_o !== 1'b0) begin
            errors++; $display("FAIL rst_no_valid: pulses %0d bsy %b want 0 0", cv_cnt - c0, bsy_o);
        end
        // Synchronous reset in the middle of a handshake.
        send_cmd(80'h0, 1);
        wait_req(1'b1, ok);
        ack_i = 1'b1; reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_o !== 1'b0 || bsy_o !== 1'b0 || cmd_len_o !== 4'd0) begin
            errors++; $display("FAIL reset_mid: req %b bsy %b len %0d want 0 0 0", req_o, bsy_o, cmd_len_o);
        end
        reset = 1'b0; ack_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cv_cnt !== c0) begin errors++; $display("FAIL reset_mid_valid: pulses %0d want 0", cv_cnt - c0); end
    endtask

    task automatic test_timeout();
        bit ok;
        send_cmd(80'h0, 6);
        status_i = 8'h11; status_valid_i = 1'b1;
        @(negedge clk);
        status_valid_i = 1'b0;
        wait_req(1'b1, ok);
        checks++;
        if (!ok || {msg_o, cd_o, io_o} !== 3'b011) begin
            errors++; $display("FAIL to_status: req %b phase %b want 1 011", req_o, {msg_o, cd_o, io_o});
        end
`ifdef PCECD_TARGET_TIMEOUT_EN
        repeat (15) @(negedge clk);
        checks++;
        if (bsy_o !== 1'b1) begin errors++; $display("FAIL to_early: bsy %b want 1", bsy_o); end
        @(negedge clk);
        checks++;
        if (bsy_o !== 1'b0 || req_o !== 1'b0) begin
            errors++; $display("FAIL to_fire: bsy %b req %b want 0 0", bsy_o, req_o);
        end
`else
        begin
            bit stuck;
            stuck = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (bsy_o !== 1'b1 || req_o !== 1'b1) stuck = 1'b0;
            end
            checks++;
            if (!stuck) begin errors++; $display("FAIL no_timeout: bsy %b req %b want 1 1", bsy_o, req_o); end
        end
`endif
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cmd6();
        test_cmd10();
        test_data_in();
        test_exec_both();
        test_rst_mid_cmd();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcecd_scsi_target.md
PCECD_SCSI_TARGET -- requirements
Module: pcecd_scsi_target

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 65535: watchdog limit in clk cycles, used only with PCECD_TARGET_TIMEOUT_EN.
REQ-002 clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 sel_i  in  1  initiator SEL.
REQ-005 ack_i  in  1  initiator ACK.
REQ-006 rst_i  in  1  initiator bus RST.
REQ-007 db_i  in  8  initiator-to-target data bus.
REQ-008 db_o  out  8  target-to-initiator data bus.
REQ-009 bsy_o, req_o, msg_o, cd_o, io_o  out  1 each  target bus signals.
REQ-010 cmd_o  out  80  command bytes; byte 0 in [7:0].
REQ-011 cmd_len_o  out  4  command length, 6 or 10.
REQ-012 cmd_valid_o  out  1  one-cycle pulse, command complete.
REQ-013 data_i  in  8  DATA IN byte from drive backend.
REQ-014 data_valid_i  in  1  data_i is valid.
REQ-015 data_ready_o  out  1  data_i consumed this cycle.
REQ-016 status_valid_i  in  1  end data, enter STATUS.
REQ-017 status_i  in  8  status byte, sampled when status_valid_i accepted.

Function
REQ-018 States SHALL be BUS_FREE, COMMAND, EXEC, DATA_IN, STATUS, MSG_IN.
REQ-019 Phase encoding {msg,cd,io} SHALL be COMMAND 010, DATA_IN 001, STATUS 011, MSG_IN 111; BUS_FREE and EXEC drive 000.
REQ-020 bsy_o SHALL be 1 in every state except BUS_FREE.
REQ-021 BUS_FREE -> COMMAND on the first cycle sel_i=1; bsy_o rises one cycle after sel_i is sampled.
REQ-022 Handshake: target drives db_o/phase, then raises req_o; on a cycle with req_o=1 and ack_i=1 the target latches db_i (COMMAND) or advances the byte index, and drops req_o next cycle; req_o SHALL not re-rise until ack_i is sampled 0.
REQ-023 COMMAND: byte 0 opcode[7:5]=0 sets length 6, any other group sets 10; bytes stored at cmd_o[8*i+7:8*i].
REQ-024 After the last command byte's ACK clears, cmd_valid_o pulses once and the state goes to EXEC; cmd_o/cmd_len_o hold until the next COMMAND entry.
REQ-025 EXEC: data_valid_i=1 -> DATA_IN; status_valid_i=1 -> STATUS; both set -> DATA_IN first (status latched, entered after data).
REQ-026 DATA_IN: data_ready_o pulses one cycle when data_i is loaded into db_o, only when req_o=0 and ack_i=0; status_valid_i with no data pending -> STATUS.
REQ-027 STATUS: db_o=status; after handshake -> MSG_IN with db_o=8'h00 (COMMAND COMPLETE); after handshake -> BUS_FREE.
REQ-028 rst_i=1 in any state SHALL force BUS_FREE next cycle, clear all outputs, and discard partial commands; rst_i dominates sel_i.
REQ-029 sel_i asserted outside BUS_FREE SHALL be ignored.

Reset
REQ-030 On reset: state BUS_FREE; bsy_o, req_o, msg_o, cd_o, io_o, cmd_valid_o, data_ready_o = 0; db_o=8'h00; cmd_o=0; cmd_len_o=0; internal status latch cleared.
REQ-031 Reset mid-handshake SHALL drop req_o the cycle after reset is sampled, with no cmd_valid_o pulse.

Configuration
REQ-032 Macro PCECD_TARGET_TIMEOUT_EN defined: a counter restarts on every req_o rise and on every ack_i fall; if req_o stays 1 for TIMEOUT_CYCLES cycles without ack_i, the block enters BUS_FREE exactly as on rst_i.
REQ-033 Macro undefined: no counter; the block waits for ACK indefinitely.

Verification
REQ-034 sel_i pulse, bytes 00 00 00 00 00 00 with ACK -> phase 010 for six REQs, cmd_len_o=6, one cmd_valid_o pulse, cmd_o=0.
REQ-035 Command D8 01 02 03 04 05 06 07 08 09 -> ten REQs, cmd_len_o=10, cmd_o[7:0]=8'hD8, cmd_o[79:72]=8'h09.
REQ-036 EXEC, 3 data bytes AA BB CC then status_valid_i with status 8'h02 -> DATA_IN bytes in order, STATUS db_o=8'h02, MSG_IN db_o=8'h00, then bsy_o=0.
REQ-037 rst_i during 4th command byte -> BUS_FREE next cycle, all bus outputs 0, no cmd_valid_o.
REQ-038 With PCECD_TARGET_TIMEOUT_EN and TIMEOUT_CYCLES=16, ACK withheld in STATUS -> bsy_o=0 after 16 cycles; without the macro, bsy_o stays 1 for 1000 cycles.
